id_ex_stage: RTL and testbench

- Parametrised ID/EX pipeline register for the 8-stage pipelined CPU.
- Latches the decoded instruction, op code and register operands, and drives ALU operands a/b and aluc to the EX stage.
- Added behaviour: valid bit, stall hold, flush bubble, EX/MEM and MEM/WB operand forwarding, destination/write-enable decode, and forward-refresh of held operands while stalled.

---
 rtl/id_ex_stage_pkg.sv | 43 ++++
 rtl/id_ex_stage_if.sv | 47 ++++
 rtl/id_ex_stage_fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: op codes, ALU control codes,
// instruction field positions and forwarding-select encodings.
package id_ex_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned SH_MSB  = 10;
    localparam int unsigned SH_LSB  = 6;
    localparam int unsigned IMM_MSB = 15;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_ADDU  = 4'd2;
    localparam logic [3:0] OP_SUBU  = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_ADDIU = 4'd6;
    localparam logic [3:0] OP_LW    = 4'd7;
    localparam logic [3:0] OP_SW    = 4'd8;
    localparam logic [3:0] OP_SLL   = 4'd9;
    localparam logic [3:0] OP_BEQ   = 4'd10;
    localparam logic [3:0] OP_BNE   = 4'd11;

    // Nonzero so a real ALU request never aliases the idle code 0.
    localparam logic [3:0] ALUC_ADDU = 4'd1;
    localparam logic [3:0] ALUC_ADD  = 4'd2;
    localparam logic [3:0] ALUC_SUBU = 4'd3;
    localparam logic [3:0] ALUC_SUB  = 4'd4;
    localparam logic [3:0] ALUC_SLTU = 4'd5;
    localparam logic [3:0] ALUC_SLL  = 4'd6;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side inputs, bypass ports and EX-side outputs.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned ALUC_W = 4,
    parameter int unsigned REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic [31:0]       instr;
    logic [OP_W-1:0]   doing_op;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              exmem_wen;
    logic [REG_AW-1:0] exmem_dst;
    logic [DATA_W-1:0] exmem_data;
    logic              memwb_wen;
    logic [REG_AW-1:0] memwb_dst;
    logic [DATA_W-1:0] memwb_data;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ALUC_W-1:0] aluc;
    logic [DATA_W-1:0] store_data;
    logic [31:0]       instr_id_ex;
    logic [OP_W-1:0]   doing_op_id_ex;
    logic              valid_id_ex;
    logic [REG_AW-1:0] dst_id_ex;
    logic              wen_id_ex;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;

    modport master (
        output stall, flush, instr, doing_op, rs, rt,
               exmem_wen, exmem_dst, exmem_data,
               memwb_wen, memwb_dst, memwb_data,
        input  a, b, aluc, store_data, instr_id_ex, doing_op_id_ex,
               valid_id_ex, dst_id_ex, wen_id_ex, fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  stall, flush, instr, doing_op, rs, rt,
               exmem_wen, exmem_dst, exmem_data,
               memwb_wen, memwb_dst, memwb_data,
        output a, b, aluc, store_data, instr_id_ex, doing_op_id_ex,
               valid_id_ex, dst_id_ex, wen_id_ex, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass mux: EX/MEM beats MEM/WB beats register file; r0 never bypassed.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_wen,
    input  logic [REG_AW-1:0] exmem_dst,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wen,
    input  logic [REG_AW-1:0] memwb_dst,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] data_c,
    output fwd_sel_e          sel_c
);

    always_comb begin
        data_c = rf_data;
        sel_c  = FWD_RF;
        if (FWD_EN && (idx != '0)) begin
            if (exmem_wen && (exmem_dst == idx)) begin
                data_c = exmem_data;
                sel_c  = FWD_MEM;
            end else if (memwb_wen && (memwb_dst == idx)) begin
                data_c = memwb_data;
                sel_c  = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid, stall hold, flush bubble, operand
// forwarding and destination decode; drives ALU operands to EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned ALUC_W = 4,
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    logic [INSTR_W-1:0] instr_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  rs_q, rt_q;
    logic               valid_q;
    logic [REG_AW-1:0]  dst_q, dst_d;
    logic               wen_q;

    logic [DATA_W-1:0]  fa, fb, imm_s, shamt;
    fwd_sel_e           sel_a, sel_b;
    logic [DATA_W-1:0]  a_c, b_c;
    logic [ALUC_W-1:0]  aluc_c;

    // Destination decoded from the incoming instruction so dst/wen leave registered.
    always_comb begin
        dst_d = '0;
        case (bus.doing_op)
            OP_W'(OP_ADD), OP_W'(OP_ADDU), OP_W'(OP_SUBU),
            OP_W'(OP_SLTU), OP_W'(OP_SLL):
                dst_d = REG_AW'(bus.instr[RD_MSB:RD_LSB]);
            OP_W'(OP_ADDI), OP_W'(OP_ADDIU), OP_W'(OP_LW):
                dst_d = REG_AW'(bus.instr[RT_MSB:RT_LSB]);
            default: dst_d = '0;
        endcase
    end

    // Stalled operands take their forwarded value so a retiring writeback is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
            dst_q   <= '0;
            wen_q   <= 1'b0;
        end else if (bus.flush) begin
            instr_q <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
            dst_q   <= '0;
            wen_q   <= 1'b0;
        end else if (bus.stall) begin
            rs_q <= fa;
            rt_q <= fb;
        end else begin
            instr_q <= bus.instr;
            op_q    <= bus.doing_op;
            rs_q    <= bus.rs;
            rt_q    <= bus.rt;
            valid_q <= (bus.doing_op != OP_W'(OP_NOP));
            dst_q   <= dst_d;
            wen_q   <= (bus.doing_op != OP_W'(OP_NOP)) && (dst_d != '0);
        end
    end

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .idx        (REG_AW'(instr_q[RS_MSB:RS_LSB])),
        .rf_data    (rs_q),
        .exmem_wen  (bus.exmem_wen),
        .exmem_dst  (bus.exmem_dst),
        .exmem_data (bus.exmem_data),
        .memwb_wen  (bus.memwb_wen),
        .memwb_dst  (bus.memwb_dst),
        .memwb_data (bus.memwb_data),
        .data_c     (fa),
        .sel_c      (sel_a)
    );

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .idx        (REG_AW'(instr_q[RT_MSB:RT_LSB])),
        .rf_data    (rt_q),
        .exmem_wen  (bus.exmem_wen),
        .exmem_dst  (bus.exmem_dst),
        .exmem_data (bus.exmem_data),
        .memwb_wen  (bus.memwb_wen),
        .memwb_dst  (bus.memwb_dst),
        .memwb_data (bus.memwb_data),
        .data_c     (fb),
        .sel_c      (sel_b)
    );

    assign imm_s = DATA_W'($signed(instr_q[IMM_MSB:0]));
    assign shamt = DATA_W'(instr_q[SH_MSB:SH_LSB]);

    // ALU operand and control selection; an invalid stage presents zeros.
    always_comb begin
        a_c    = '0;
        b_c    = '0;
        aluc_c = '0;
        if (valid_q) begin
            case (op_q)
                OP_W'(OP_ADD):   begin a_c = fa;    b_c = fb;    aluc_c = ALUC_W'(ALUC_ADD);  end
                OP_W'(OP_ADDU):  begin a_c = fa;    b_c = fb;    aluc_c = ALUC_W'(ALUC_ADDU); end
                OP_W'(OP_SUBU):  begin a_c = fa;    b_c = fb;    aluc_c = ALUC_W'(ALUC_SUBU); end
                OP_W'(OP_SLTU):  begin a_c = fa;    b_c = fb;    aluc_c = ALUC_W'(ALUC_SLTU); end
                OP_W'(OP_ADDI),
                OP_W'(OP_LW),
                OP_W'(OP_SW):    begin a_c = fa;    b_c = imm_s; aluc_c = ALUC_W'(ALUC_ADD);  end
                OP_W'(OP_ADDIU): begin a_c = fa;    b_c = imm_s; aluc_c = ALUC_W'(ALUC_ADDU); end
                OP_W'(OP_SLL):   begin a_c = shamt; b_c = fb;    aluc_c = ALUC_W'(ALUC_SLL);  end
                OP_W'(OP_BEQ),
                OP_W'(OP_BNE):   begin a_c = fa;    b_c = fb;    aluc_c = ALUC_W'(ALUC_SUB);  end
                default: ;
            endcase
        end
    end

    assign bus.a              = a_c;
    assign bus.b              = b_c;
    assign bus.aluc           = aluc_c;
    assign bus.store_data     = fb;
    assign bus.instr_id_ex    = instr_q;
    assign bus.doing_op_id_ex = op_q;
    assign bus.valid_id_ex    = valid_q;
    assign bus.dst_id_ex      = dst_q;
    assign bus.wen_id_ex      = wen_q;
    assign bus.fwd_sel_a      = sel_a;
    assign bus.fwd_sel_b      = sel_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors queue expected outputs,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    id_ex_stage_if #(.DATA_W(32), .OP_W(4), .ALUC_W(4), .REG_AW(5)) bus();

    id_ex_stage #(.DATA_W(32), .OP_W(4), .ALUC_W(4), .REG_AW(5), .FWD_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           cyc;
        logic [146:0] v;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [146:0] mon_got;

    // Monitor: compare every queued expectation in the cycle it falls due.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e   = sb_q.pop_front();
            mon_got = {bus.a, bus.b, bus.aluc, bus.store_data, bus.instr_id_ex,
                       bus.doing_op_id_ex, bus.valid_id_ex, bus.dst_id_ex,
                       bus.wen_id_ex, bus.fwd_sel_a, bus.fwd_sel_b};
            n_checks++;
            if (mon_e.cyc != cyc)
                $display("FAIL %s missed its cycle (due %0d, now %0d)", mon_e.name, mon_e.cyc, cyc);
            else if (mon_got !== mon_e.v)
                $display("FAIL %s got a=%h b=%h aluc=%h sd=%h instr=%h op=%h v=%b dst=%0d wen=%b sa=%0d sb=%0d | want %h",
                         mon_e.name, bus.a, bus.b, bus.aluc, bus.store_data, bus.instr_id_ex,
                         bus.doing_op_id_ex, bus.valid_id_ex, bus.dst_id_ex, bus.wen_id_ex,
                         bus.fwd_sel_a, bus.fwd_sel_b, mon_e.v);
            else
                n_pass++;
        end
    end

    task automatic expect_at(input string nm, input int off,
                             input logic [31:0] a, input logic [31:0] b, input logic [3:0] aluc,
                             input logic [31:0] sd, input logic [31:0] ins, input logic [3:0] op,
                             input logic vld, input logic [4:0] dst, input logic wen,
                             input logic [1:0] sa, input logic [1:0] sbs);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + off;
        e.v    = {a, b, aluc, sd, ins, op, vld, dst, wen, sa, sbs};
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] ins, input logic [3:0] op,
                          input logic [31:0] rsv, input logic [31:0] rtv);
        bus.instr = ins; bus.doing_op = op; bus.rs = rsv; bus.rt = rtv;
    endtask

    task automatic set_ex(input logic w, input logic [4:0] d, input logic [31:0] v);
        bus.exmem_wen = w; bus.exmem_dst = d; bus.exmem_data = v;
    endtask

    task automatic set_wb(input logic w, input logic [4:0] d, input logic [31:0] v);
        bus.memwb_wen = w; bus.memwb_dst = d; bus.memwb_data = v;
    endtask

    logic [31:0] i_addi, i_add, i_add0, i_subu, i_sll3, i_sll31, i_sw, i_beq, i_addiu;

    initial begin
        i_addi  = enc_i(6'h08, 5'd1, 5'd2, 16'hFFFC);
        i_add   = enc_r(5'd1, 5'd2, 5'd3, 5'd0);
        i_add0  = enc_r(5'd0, 5'd2, 5'd3, 5'd0);
        i_subu  = enc_r(5'd9, 5'd10, 5'd8, 5'd0);
        i_sll3  = enc_r(5'd0, 5'd5, 5'd4, 5'd3);
        i_sll31 = enc_r(5'd0, 5'd5, 5'd4, 5'd31);
        i_sw    = enc_i(6'h2B, 5'd6, 5'd7, 16'd8);
        i_beq   = enc_i(6'h04, 5'd1, 5'd2, 16'h0010);
        i_addiu = enc_i(6'h09, 5'd4, 5'd5, 16'h7FFF);

        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_id(32'd0, 4'd0, 32'd0, 32'd0);
        set_ex(1'b0, 5'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);

        expect_at("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;

        set_id(i_addi, OP_ADDI, 32'd10, 32'h1234);
        expect_at("addi", 1, 32'd10, 32'hFFFF_FFFC, ALUC_ADD, 32'h1234, i_addi, OP_ADDI, 1, 5'd2, 1, 0, 0);
        step();

        set_id(i_add, OP_ADD, 32'h11, 32'h22);
        expect_at("add_load", 1, 32'h11, 32'h22, ALUC_ADD, 32'h22, i_add, OP_ADD, 1, 5'd3, 1, 0, 0);
        step();

        set_ex(1'b1, 5'd1, 32'h55);
        set_wb(1'b1, 5'd1, 32'h66);
        expect_at("fwd_exmem_wins", 1, 32'h55, 32'h22, ALUC_ADD, 32'h22, i_add, OP_ADD, 1, 5'd3, 1, 2, 0);
        step();

        set_ex(1'b0, 5'd1, 32'h55);
        expect_at("fwd_memwb", 1, 32'h66, 32'h22, ALUC_ADD, 32'h22, i_add, OP_ADD, 1, 5'd3, 1, 1, 0);
        step();

        set_ex(1'b1, 5'd2, 32'h77);
        expect_at("fwd_mixed", 1, 32'h66, 32'h77, ALUC_ADD, 32'h77, i_add, OP_ADD, 1, 5'd3, 1, 1, 2);
        step();

        set_id(i_add0, OP_ADD, 32'hAB, 32'h22);
        set_ex(1'b1, 5'd0, 32'h55);
        set_wb(1'b1, 5'd0, 32'h66);
        expect_at("fwd_r0_blocked", 1, 32'hAB, 32'h22, ALUC_ADD, 32'h22, i_add0, OP_ADD, 1, 5'd3, 1, 0, 0);
        step();

        set_id(i_subu, OP_SUBU, 32'h100, 32'h200);
        set_ex(1'b0, 5'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        expect_at("subu_load", 1, 32'h100, 32'h200, ALUC_SUBU, 32'h200, i_subu, OP_SUBU, 1, 5'd8, 1, 0, 0);
        step();

        bus.stall = 1'b1;
        set_id(i_addi, OP_ADDI, 32'hDEAD, 32'hBEEF);
        set_wb(1'b1, 5'd10, 32'h99);
        expect_at("stall_wb_pulse", 1, 32'h100, 32'h99, ALUC_SUBU, 32'h99, i_subu, OP_SUBU, 1, 5'd8, 1, 0, 1);
        step();

        set_wb(1'b0, 5'd10, 32'h99);
        expect_at("stall_refreshed", 1, 32'h100, 32'h99, ALUC_SUBU, 32'h99, i_subu, OP_SUBU, 1, 5'd8, 1, 0, 0);
        step();

        bus.flush = 1'b1;
        set_id(i_sll3, OP_SLL, 32'd0, 32'd5);
        expect_at("flush_over_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_id(i_sll31, OP_SLL, 32'd0, 32'd5);
        expect_at("sll_shamt31", 1, 32'd31, 32'd5, ALUC_SLL, 32'd5, i_sll31, OP_SLL, 1, 5'd4, 1, 0, 0);
        step();

        set_id(i_sw, OP_SW, 32'h1000, 32'h42);
        set_wb(1'b1, 5'd7, 32'h77);
        expect_at("sw_store_fwd", 1, 32'h1000, 32'd8, ALUC_ADD, 32'h77, i_sw, OP_SW, 1, 5'd0, 0, 0, 1);
        step();

        set_id(i_beq, OP_BEQ, 32'd5, 32'd6);
        set_wb(1'b0, 5'd0, 32'd0);
        expect_at("beq", 1, 32'd5, 32'd6, ALUC_SUB, 32'd6, i_beq, OP_BEQ, 1, 5'd0, 0, 0, 0);
        step();

        set_id(i_add, 4'hF, 32'd7, 32'd9);
        expect_at("unknown_op", 1, 0, 0, 0, 32'd9, i_add, 4'hF, 1, 5'd0, 0, 0, 0);
        step();

        set_id(i_addiu, OP_ADDIU, 32'd1, 32'd2);
        expect_at("addiu", 1, 32'd1, 32'h7FFF, ALUC_ADDU, 32'd2, i_addiu, OP_ADDIU, 1, 5'd5, 1, 0, 0);
        step();

        bus.stall = 1'b1;
        set_id(i_add, OP_NOP, 32'd5, 32'd6);
        expect_at("stall_hold", 1, 32'd1, 32'h7FFF, ALUC_ADDU, 32'd2, i_addiu, OP_ADDIU, 1, 5'd5, 1, 0, 0);
        step();

        // Reset raised between edges while stalled must clear the stage at once.
        @(posedge clk);
        #2;
        reset = 1'b1;
        expect_at("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        bus.stall = 1'b0;

        expect_at("nop_load", 1, 0, 0, 0, 32'd6, i_add, OP_NOP, 0, 5'd0, 0, 0, 0);
        step();

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain got %0d pending, want 0", sb_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
